match_controller: RTL and testbench

//  Sequences a best-of-N fighting match around the game logic: start countdown, round timer, KO/timeout judging, round scoring, match-over.

---
 rtl/match_controller.sv | 174 +++++++++++++++++
 tb/tb_match_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Best-of-N match sequencer: pre-round countdown, round timer, KO/timeout judging,
// round scoring and match-over. All outputs are registered.

module match_controller #(
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ROUND_TIME    = 99,
  parameter int TICKS_PER_SEC = 60,
  parameter int COUNTDOWN_SEC = 3,
  parameter int KO_HOLD_SEC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_btn,
  input  logic [3:0] p1_health,
  input  logic [3:0] p2_health,
  output logic       freeze,
  output logic       round_reset,
  output logic [2:0] phase,
  output logic [6:0] timer,
  output logic [1:0] countdown,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic [2:0] round_num,
  output logic [1:0] winstate
);

  typedef enum logic [2:0] {
    PH_IDLE       = 3'd0,
    PH_COUNTDOWN  = 3'd1,
    PH_FIGHT      = 3'd2,
    PH_ROUND_END  = 3'd3,
    PH_MATCH_OVER = 3'd4
  } phase_t;

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HOLD_W = (KO_HOLD_SEC > 1) ? $clog2(KO_HOLD_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(KO_HOLD_SEC - 1);
  localparam logic [1:0]        WINS_TARGET = 2'(ROUNDS_TO_WIN);
  localparam logic [6:0]        TIMER_INIT  = 7'(ROUND_TIME);
  localparam logic [1:0]        COUNT_INIT  = 2'(COUNTDOWN_SEC);

  phase_t            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              start_q;
  logic              start_rise, sec_pulse, entering;
  logic              p1_ko, p2_ko, p1_point, p2_point;
  logic              freeze_d, round_reset_d;
  logic [6:0]        timer_d;
  logic [1:0]        countdown_d, p1_wins_d, p2_wins_d, winstate_d;
  logic [2:0]        round_num_d;

  assign phase      = state_q;
  assign start_rise = start_btn & ~start_q;
  assign sec_pulse  = tick && (tick_cnt_q == TICK_LAST);
  assign p1_ko      = (p1_health == 4'd0);
  assign p2_ko      = (p2_health == 4'd0);

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    timer_d     = timer;
    countdown_d = countdown;
    p1_wins_d   = p1_wins;
    p2_wins_d   = p2_wins;
    round_num_d = round_num;
    winstate_d  = winstate;
    p1_point    = 1'b0;
    p2_point    = 1'b0;

    case (state_q)
      PH_IDLE: begin
        if (start_rise) state_d = PH_COUNTDOWN;
      end
      PH_COUNTDOWN: begin
        if (sec_pulse) begin
          if (countdown != 2'd0) countdown_d = countdown - 2'd1;
          if (countdown <= 2'd1) state_d = PH_FIGHT;
        end
      end
      PH_FIGHT: begin
        if (sec_pulse && timer != 7'd0) timer_d = timer - 7'd1;
        // KO outranks the clock; a double KO is a draw
        if (p1_ko && p2_ko) begin
          state_d = PH_ROUND_END;
        end else if (p1_ko) begin
          state_d  = PH_ROUND_END;
          p2_point = 1'b1;
        end else if (p2_ko) begin
          state_d  = PH_ROUND_END;
          p1_point = 1'b1;
        end else if (sec_pulse && timer <= 7'd1) begin
          state_d  = PH_ROUND_END;
          p1_point = (p1_health > p2_health);
          p2_point = (p2_health > p1_health);
        end
        if (state_d == PH_ROUND_END) begin
          if (p1_point && p1_wins != 2'd3) p1_wins_d = p1_wins + 2'd1;
          if (p2_point && p2_wins != 2'd3) p2_wins_d = p2_wins + 2'd1;
          if (round_num != 3'd7) round_num_d = round_num + 3'd1;
        end
      end
      PH_ROUND_END: begin
        if (sec_pulse) begin
          if (hold_cnt_q == HOLD_LAST)
            state_d = (p1_wins == WINS_TARGET || p2_wins == WINS_TARGET) ? PH_MATCH_OVER : PH_COUNTDOWN;
          else
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      PH_MATCH_OVER: begin
        if (start_rise) begin
          p1_wins_d   = 2'd0;
          p2_wins_d   = 2'd0;
          round_num_d = 3'd0;
          winstate_d  = 2'b00;
          state_d     = PH_COUNTDOWN;
        end
      end
      default: state_d = PH_IDLE;
    endcase

    entering = (state_d != state_q);
    if (entering) hold_cnt_d = '0;
    if (entering && state_d == PH_COUNTDOWN) begin
      countdown_d = COUNT_INIT;
      timer_d     = TIMER_INIT;
    end
    if (entering && state_d == PH_MATCH_OVER)
      winstate_d = (p1_wins == WINS_TARGET) ? 2'b10 : 2'b01;

    // the second counter restarts on every phase entry so each phase gets whole seconds
    if (entering || sec_pulse) tick_cnt_d = '0;
    else if (tick)             tick_cnt_d = tick_cnt_q + TICK_W'(1);
    else                       tick_cnt_d = tick_cnt_q;

    freeze_d      = (state_d != PH_FIGHT);
    round_reset_d = entering && (state_d == PH_COUNTDOWN);
  end

  // start_q comes out of reset set, so a button already held at reset release is not a press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PH_IDLE;
      tick_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      start_q     <= 1'b1;
      freeze      <= 1'b1;
      round_reset <= 1'b0;
      timer       <= TIMER_INIT;
      countdown   <= 2'd0;
      p1_wins     <= 2'd0;
      p2_wins     <= 2'd0;
      round_num   <= 3'd0;
      winstate    <= 2'b00;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      start_q     <= start_btn;
      freeze      <= freeze_d;
      round_reset <= round_reset_d;
      timer       <= timer_d;
      countdown   <= countdown_d;
      p1_wins     <= p1_wins_d;
      p2_wins     <= p2_wins_d;
      round_num   <= round_num_d;
      winstate    <= winstate_d;
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Self-checking bench for match_controller: scenario tasks plus a random soak,
// all compared against a second-level behavioural model of the match rules.

module tb_match_controller;
  localparam int TPS = 2, RT = 5, CDS = 3, KOH = 1, RTW = 2;

  logic       clk = 1'b0;
  logic       rst, tick, start_btn;
  logic [3:0] p1_health, p2_health;
  logic       freeze, round_reset;
  logic [2:0] phase, round_num;
  logic [6:0] timer;
  logic [1:0] countdown, p1_wins, p2_wins, winstate;

  int checks = 0;
  int failures = 0;
  int tick_div = 0;

  match_controller #(
    .ROUNDS_TO_WIN(RTW), .ROUND_TIME(RT), .TICKS_PER_SEC(TPS),
    .COUNTDOWN_SEC(CDS), .KO_HOLD_SEC(KOH)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start_btn(start_btn),
    .p1_health(p1_health), .p2_health(p2_health),
    .freeze(freeze), .round_reset(round_reset), .phase(phase), .timer(timer),
    .countdown(countdown), .p1_wins(p1_wins), .p2_wins(p2_wins),
    .round_num(round_num), .winstate(winstate)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (tick_div % 4 == 3);
      tick_div++;
    end
  end

  // Reference model: phases 0..4 as integers, seconds counted in whole ticks
  int m_phase, m_timer, m_cd, m_p1w, m_p2w, m_rn, m_ws, m_ticks, m_hold;
  bit m_freeze, m_rr, m_prev;

  function automatic int bump(int v, int cap);
    return (v < cap) ? v + 1 : cap;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_timer = RT; m_cd = 0; m_p1w = 0; m_p2w = 0; m_rn = 0; m_ws = 0;
    m_ticks = 0; m_hold = 0; m_freeze = 1; m_rr = 0; m_prev = 1;
  endtask

  task automatic model_step();
    bit rise, sec;
    int nxt, winner;
    rise = start_btn && !m_prev;
    m_prev = start_btn;
    sec = 0;
    if (tick) begin
      m_ticks++;
      if (m_ticks == TPS) begin sec = 1; m_ticks = 0; end
    end
    nxt = m_phase;
    winner = 0;
    case (m_phase)
      0: if (rise) nxt = 1;
      1: if (sec) begin m_cd--; if (m_cd == 0) nxt = 2; end
      2: begin
        if (sec && m_timer > 0) m_timer--;
        if (p1_health == 0 || p2_health == 0) begin
          nxt = 3;
          if (p1_health == 0 && p2_health == 0) winner = 0;
          else winner = (p1_health == 0) ? 2 : 1;
        end else if (sec && m_timer == 0) begin
          nxt = 3;
          winner = (p1_health > p2_health) ? 1 : (p2_health > p1_health) ? 2 : 0;
        end
        if (nxt == 3) begin
          if (winner == 1) m_p1w = bump(m_p1w, 3);
          if (winner == 2) m_p2w = bump(m_p2w, 3);
          m_rn = bump(m_rn, 7);
        end
      end
      3: if (sec) begin
        m_hold++;
        if (m_hold >= KOH) nxt = (m_p1w == RTW || m_p2w == RTW) ? 4 : 1;
      end
      4: if (rise) begin m_p1w = 0; m_p2w = 0; m_rn = 0; m_ws = 0; nxt = 1; end
      default: nxt = 0;
    endcase
    m_rr = 0;
    if (nxt != m_phase) begin
      m_ticks = 0;
      m_hold = 0;
      if (nxt == 1) begin m_cd = CDS; m_timer = RT; m_rr = 1; end
      if (nxt == 4) m_ws = (m_p1w == RTW) ? 2 : 1;
    end
    m_freeze = (nxt != 2);
    m_phase = nxt;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  wire [22:0] dut_vec = {freeze, round_reset, phase, timer, countdown, p1_wins, p2_wins, round_num, winstate};
  localparam logic [22:0] RESET_VEC = {1'b1, 1'b0, 3'd0, 7'(RT), 2'd0, 2'd0, 2'd0, 3'd0, 2'b00};

  function automatic logic [22:0] exp_vec();
    return {m_freeze, m_rr, 3'(m_phase), 7'(m_timer), 2'(m_cd), 2'(m_p1w), 2'(m_p2w), 3'(m_rn), 2'(m_ws)};
  endfunction

  task automatic test_reset();
    rst = 1'b0; start_btn = 1'b0; p1_health = 4'd15; p2_health = 4'd15;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec !== RESET_VEC) begin
      failures++; $display("[TB] FAIL reset_values got=%h want=%h", dut_vec, RESET_VEC);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL reset_release got=%h want=%h", dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_countdown();
    int rr_seen = 0, t_cd2 = -1, t_cd1 = -1, t_fight = -1;
    repeat ($urandom_range(1, 6)) @(negedge clk);
    start_btn = 1'b1;
    for (int c = 0; c < 60 && t_fight < 0; c++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL countdown_track got=%h want=%h", dut_vec, exp_vec()); end
      if (c == 0) begin
        checks++;
        if ({phase, countdown, round_reset} !== {3'd1, 2'd3, 1'b1}) begin
          failures++; $display("[TB] FAIL countdown_entry got=%h want=%h", {phase, countdown, round_reset}, {3'd1, 2'd3, 1'b1});
        end
      end
      if (c == 2) start_btn = 1'b0;
      if (round_reset) rr_seen++;
      if (t_cd2 < 0 && countdown == 2'd2) t_cd2 = c;
      if (t_cd1 < 0 && countdown == 2'd1) t_cd1 = c;
      if (t_fight < 0 && phase == 3'd2) t_fight = c;
    end
    checks++;
    if (t_fight < 0) begin failures++; $display("[TB] FAIL countdown_timeout got=no_fight want=fight"); end
    checks++;
    if (rr_seen != 1) begin failures++; $display("[TB] FAIL round_reset_pulses got=%0d want=1", rr_seen); end
    checks++;
    if (t_cd1 - t_cd2 != 8 || t_fight - t_cd1 != 8) begin
      failures++; $display("[TB] FAIL countdown_spacing got=%0d,%0d want=8,8", t_cd1 - t_cd2, t_fight - t_cd1);
    end
    checks++;
    if ({phase, freeze} !== {3'd2, 1'b0}) begin failures++; $display("[TB] FAIL fight_unfreeze got=%h want=%h", {phase, freeze}, {3'd2, 1'b0}); end
  endtask

  task automatic test_ko();
    bit done = 0;
    repeat ($urandom_range(0, 8)) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL ko_fight got=%h want=%h", dut_vec, exp_vec()); end
    end
    p2_health = 4'd0;
    @(negedge clk); checks++;
    if ({phase, p1_wins, freeze} !== {3'd3, 2'd1, 1'b1}) begin
      failures++; $display("[TB] FAIL ko_p1_scores got=%h want=%h", {phase, p1_wins, freeze}, {3'd3, 2'd1, 1'b1});
    end
    p2_health = 4'($urandom_range(1, 15));
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL ko_hold got=%h want=%h", dut_vec, exp_vec()); end
      done = (phase == 3'd1);
    end
    checks++;
    if (!done || round_reset !== 1'b1) begin
      failures++; $display("[TB] FAIL ko_next_round got=%h want=%h", {phase, round_reset}, {3'd1, 1'b1});
    end
  endtask

  task automatic test_timeout();
    bit seen_fight = 0, seq_ok = 1, done = 0;
    int last = -1, steps = 0, h;
    p1_health = 4'd5; p2_health = 4'd9;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL timeout_track got=%h want=%h", dut_vec, exp_vec()); end
      if (phase == 3'd2) begin
        seen_fight = 1;
        if (int'(timer) != last) begin
          if ((last < 0 && timer != 7'(RT)) || (last >= 0 && int'(timer) != last - 1)) seq_ok = 0;
          last = int'(timer);
          steps++;
        end
      end
      done = seen_fight && (phase == 3'd3);
    end
    checks++;
    if (!done || !seq_ok || steps != 5) begin failures++; $display("[TB] FAIL timer_sequence got=%0d steps ok=%0d want=5 steps ok=1", steps, seq_ok); end
    checks++;
    if ({phase, timer, p1_wins, p2_wins} !== {3'd3, 7'd0, 2'd1, 2'd1}) begin
      failures++; $display("[TB] FAIL timeout_p2_scores got=%h want=%h", {phase, timer, p1_wins, p2_wins}, {3'd3, 7'd0, 2'd1, 2'd1});
    end
    h = $urandom_range(1, 15);
    p1_health = 4'(h); p2_health = 4'(h);
    seen_fight = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL draw_track got=%h want=%h", dut_vec, exp_vec()); end
      if (phase == 3'd2) seen_fight = 1;
      done = seen_fight && (phase == 3'd3);
    end
    checks++;
    if (!done || {p1_wins, p2_wins, round_num} !== {2'd1, 2'd1, 3'd3}) begin
      failures++; $display("[TB] FAIL timeout_draw got=%h want=%h", {p1_wins, p2_wins, round_num}, {2'd1, 2'd1, 3'd3});
    end
  endtask

  task automatic test_match_over();
    bit done = 0;
    p1_health = 4'd15; p2_health = 4'd15;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL to_fight4 got=%h want=%h", dut_vec, exp_vec()); end
      done = (phase == 3'd2);
    end
    repeat ($urandom_range(0, 8)) @(negedge clk);
    p1_health = 4'd0; p2_health = 4'd0;
    @(negedge clk); checks++;
    if (!done || {phase, p1_wins, p2_wins, round_num} !== {3'd3, 2'd1, 2'd1, 3'd4}) begin
      failures++; $display("[TB] FAIL double_ko_draw got=%h want=%h", {phase, p1_wins, p2_wins, round_num}, {3'd3, 2'd1, 2'd1, 3'd4});
    end
    p1_health = 4'd15; p2_health = 4'd15;
    done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL to_fight5 got=%h want=%h", dut_vec, exp_vec()); end
      done = (phase == 3'd2);
    end
    repeat ($urandom_range(0, 8)) @(negedge clk);
    p2_health = 4'd0;
    @(negedge clk); checks++;
    if (!done || {phase, p1_wins} !== {3'd3, 2'd2}) begin
      failures++; $display("[TB] FAIL final_ko got=%h want=%h", {phase, p1_wins}, {3'd3, 2'd2});
    end
    start_btn = 1'b1;
    p2_health = 4'($urandom_range(1, 15));
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL to_match_over got=%h want=%h", dut_vec, exp_vec()); end
      done = (phase == 3'd4);
    end
    checks++;
    if (!done || {winstate, freeze} !== {2'b10, 1'b1}) begin
      failures++; $display("[TB] FAIL winstate_p1 got=%h want=%h", {phase, winstate, freeze}, {3'd4, 2'b10, 1'b1});
    end
    repeat (12) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL held_start got=%h want=%h", dut_vec, exp_vec()); end
    end
    checks++;
    if (phase !== 3'd4) begin failures++; $display("[TB] FAIL held_start_ignored got=%0d want=4", phase); end
    start_btn = 1'b0;
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk); checks++;
    if ({phase, p1_wins, p2_wins, round_num, winstate, round_reset} !== {3'd1, 2'd0, 2'd0, 3'd0, 2'b00, 1'b1}) begin
      failures++; $display("[TB] FAIL restart_match got=%h want=%h", {phase, p1_wins, p2_wins, round_num, winstate, round_reset},
                           {3'd1, 2'd0, 2'd0, 3'd0, 2'b00, 1'b1});
    end
  endtask

  task automatic test_async_reset();
    bit done = 0;
    int rr_seen = 0;
    start_btn = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL to_timer3 got=%h want=%h", dut_vec, exp_vec()); end
      done = (phase == 3'd2) && (timer == 7'd3);
    end
    #2 rst = 1'b0;
    #1 checks++;
    if (!done || dut_vec !== RESET_VEC) begin failures++; $display("[TB] FAIL async_reset got=%h want=%h", dut_vec, RESET_VEC); end
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL held_through_reset got=%h want=%h", dut_vec, exp_vec()); end
      if (round_reset) rr_seen++;
    end
    checks++;
    if (phase !== 3'd0 || rr_seen != 0) begin failures++; $display("[TB] FAIL no_start_after_reset got=%0d/%0d want=0/0", phase, rr_seen); end
  endtask

  task automatic test_idle_health();
    p1_health = 4'd0;
    repeat (5) @(negedge clk);
    checks++;
    if ({phase, p1_wins, p2_wins, round_num} !== {3'd0, 2'd0, 2'd0, 3'd0}) begin
      failures++; $display("[TB] FAIL idle_ko_ignored got=%h want=%h", {phase, p1_wins, p2_wins, round_num}, {3'd0, 2'd0, 2'd0, 3'd0});
    end
    p1_health = 4'd15;
    start_btn = 1'b0;
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    p2_health = 4'd0;
    repeat (4) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL countdown_ko got=%h want=%h", dut_vec, exp_vec()); end
    end
    checks++;
    if ({phase, p1_wins, p2_wins, round_num} !== {3'd1, 2'd0, 2'd0, 3'd0}) begin
      failures++; $display("[TB] FAIL countdown_ko_ignored got=%h want=%h", {phase, p1_wins, p2_wins, round_num}, {3'd1, 2'd0, 2'd0, 3'd0});
    end
    p2_health = 4'd15;
    start_btn = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec()) begin failures++; $display("[TB] FAIL random_soak cycle=%0d got=%h want=%h", c, dut_vec, exp_vec()); end
      if ($urandom_range(0, 15) == 0) p1_health = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 15) == 0) p2_health = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 31) == 0) start_btn = ~start_btn;
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_ko();
    test_timeout();
    test_match_over();
    test_async_reset();
    test_idle_health();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
